// File: rtl/ex_hazard_controller.sv
// EX-stage hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, branch flushes,
// multi-cycle op waits, ALU forwarding selects and saturating stall/flush event counters.
module ex_hazard_controller #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  idex_rs,
    input  logic [RA_W-1:0]  idex_rt,
    input  logic [RA_W-1:0]  idex_rd,
    input  logic             idex_MemRead,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic             exmem_RegWrite,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic             memwb_RegWrite,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             exmem_hold,
    output logic             mc_abort,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    state_t state, state_nxt;
    logic   load_use;
    logic   flush_evt;

    assign load_use = idex_MemRead && (idex_rd != '0) &&
                      ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));

    // Register 0 is hardwired, so it is never a forwarding source; EX/MEM is newer and wins.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == src))
            return 2'b10;
        else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        exmem_hold  = 1'b0;
        mc_abort    = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        flush_evt   = 1'b0;
        state_nxt   = state;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = RUN;
        end else begin
            fwd_a = fwd_sel(idex_rs);
            fwd_b = fwd_sel(idex_rt);
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_evt   = 1'b1;
                        state_nxt   = FLUSH;
                    end else if (mc_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        exmem_hold = 1'b1;
                        state_nxt  = MC_WAIT;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    // An older branch resolving in MEM kills the op even if it completes now.
                    if (branch_taken) begin
                        mc_abort    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        pc_write    = 1'b1;
                        flush_evt   = 1'b1;
                        state_nxt   = FLUSH;
                    end else if (mc_done) begin
                        exmem_hold = 1'b0;
                        state_nxt  = RUN;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    state_nxt  = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed-vector bench for ex_hazard_controller; small counter width makes saturation reachable.
module tb_ex_hazard_controller;

    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [RA_W-1:0]  id_rs, id_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic             id_uses_rt, idex_MemRead, mc_start, mc_done;
    logic             exmem_RegWrite, memwb_RegWrite, branch_taken;
    logic             pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
    logic             exmem_flush, exmem_hold, mc_abort;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_tot = 0;
    int n_bad = 0;

    ex_hazard_controller #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_MemRead(idex_MemRead),
        .mc_start(mc_start), .mc_done(mc_done),
        .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite),
        .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .exmem_hold(exmem_hold), .mc_abort(mc_abort),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        idex_rs = 0; idex_rt = 0; idex_rd = 0; idex_MemRead = 0;
        mc_start = 0; mc_done = 0;
        exmem_rd = 0; exmem_RegWrite = 0; memwb_rd = 0; memwb_RegWrite = 0;
        branch_taken = 0;
    endtask

    // Advance one edge, then settle inputs/outputs well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        exmem_rd = 3; idex_rs = 3; exmem_RegWrite = 1;
        tick();
        settle();
        chk("rst_pc_write",   pc_write,    0);
        chk("rst_ifid_write", ifid_write,  0);
        chk("rst_flushes",    {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("rst_misc",       {idex_bubble, exmem_hold, mc_abort}, 3'b000);
        chk("rst_fwd_a",      fwd_a,       0);
        chk("rst_cnts",       {stall_cnt, flush_cnt}, 0);

        rst = 1'b0;
        idle();
        settle();
        chk("run_idle", {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}, 5'b11000);

        // lw $2 in EX, add $3,$2,$4 in ID
        idex_MemRead = 1; idex_rd = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1;
        settle();
        chk("lu_pc_write", {pc_write, ifid_write}, 2'b00);
        chk("lu_bubble",   idex_bubble, 1);
        tick();
        idle();
        idex_rs = 2; memwb_rd = 2; memwb_RegWrite = 1;
        settle();
        chk("lu_fwd_a",     fwd_a, 2'b01);
        chk("lu_released",  pc_write, 1);
        chk("lu_stall_cnt", stall_cnt, 1);

        // hazard only through rt
        idle();
        idex_MemRead = 1; idex_rd = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0;
        settle();
        chk("rt_unused_nostall", {pc_write, idex_bubble}, 2'b10);
        id_uses_rt = 1;
        settle();
        chk("rt_used_stall", {pc_write, idex_bubble}, 2'b01);
        tick();

        // lw $0 never stalls, $0 never forwarded
        idle();
        idex_MemRead = 1; idex_rd = 0; id_rs = 0;
        exmem_rd = 0; exmem_RegWrite = 1; idex_rs = 0;
        settle();
        chk("r0_nostall", {pc_write, idex_bubble}, 2'b10);
        chk("r0_fwd_a",   fwd_a, 2'b00);
        chk("stall_cnt_2", stall_cnt, 2);

        // branch in RUN beats a simultaneous load-use
        idle();
        branch_taken = 1;
        idex_MemRead = 1; idex_rd = 6; id_rs = 6;
        settle();
        chk("br_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("br_pc_bub",  {pc_write, idex_bubble}, 2'b10);
        tick();
        idle();
        branch_taken = 1;
        settle();
        chk("flush_state", {ifid_flush, idex_flush, exmem_flush, pc_write, ifid_write}, 5'b10011);
        chk("flush_cnt_1", flush_cnt, 1);
        tick();
        idle();
        settle();
        chk("back_run",    {ifid_flush, pc_write}, 2'b01);
        chk("flush_cnt_1b", flush_cnt, 1);

        // multi-cycle op: start cycle + 3 waits + done cycle
        mc_start = 1;
        settle();
        chk("mc_start", {pc_write, ifid_write, idex_bubble, exmem_hold}, 4'b0001);
        tick();
        mc_start = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mc_wait", {pc_write, ifid_write, exmem_hold}, 3'b001);
            tick();
        end
        mc_done = 1;
        settle();
        chk("mc_done", {pc_write, exmem_hold, mc_abort}, 3'b000);
        tick();
        idle();
        settle();
        chk("mc_release",  {pc_write, ifid_write, exmem_hold}, 3'b110);
        chk("stall_cnt_7", stall_cnt, 7);

        // branch and mc_done in the same MC_WAIT cycle
        mc_start = 1;
        tick();
        mc_start = 0; branch_taken = 1; mc_done = 1;
        settle();
        chk("abort",         mc_abort, 1);
        chk("abort_flushes", {ifid_flush, idex_flush, exmem_flush, pc_write}, 4'b1111);
        tick();
        idle();
        settle();
        chk("abort_to_flush", {ifid_flush, idex_flush}, 2'b10);
        chk("flush_cnt_2",    flush_cnt, 2);
        chk("stall_cnt_8",    stall_cnt, 8);
        tick();

        // forwarding priority and register 0
        idle();
        exmem_rd = 7; memwb_rd = 7; idex_rt = 7; exmem_RegWrite = 1; memwb_RegWrite = 1;
        settle();
        chk("fwd_b_both", fwd_b, 2'b10);
        exmem_RegWrite = 0;
        settle();
        chk("fwd_b_memwb", fwd_b, 2'b01);
        idex_rs = 9; exmem_rd = 9; exmem_RegWrite = 1; memwb_rd = 0; idex_rt = 0;
        settle();
        chk("fwd_a_exmem", fwd_a, 2'b10);
        chk("fwd_b_r0",    fwd_b, 2'b00);

        // reset in the middle of MC_WAIT
        idle();
        mc_start = 1;
        tick();
        mc_start = 0;
        rst = 1;
        settle();
        chk("rst_mc_abort", mc_abort, 0);
        chk("rst_mc_flush", {pc_write, ifid_flush, idex_flush, exmem_flush}, 4'b0111);
        tick();
        rst = 0;
        settle();
        chk("rst_mc_run",  {pc_write, exmem_hold}, 2'b10);
        chk("rst_mc_cnts", {stall_cnt, flush_cnt}, 0);

        // saturation of stall_cnt at all-ones
        idex_MemRead = 1; idex_rd = 8; id_rs = 8;
        repeat (20) tick();
        settle();
        chk("stall_sat", stall_cnt, 15);
        tick();
        settle();
        chk("stall_sat_hold", stall_cnt, 15);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
